// File: rtl/z_window_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : z_window_accumulator
//  Description : Drains 8-bit z samples over a dav_/rfd handshake and, for
//                every window of N samples, presents the window sum and
//                maximum downstream over a second dav_/rfd handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module z_window_accumulator #(
    parameter int N = 4                 // samples per window, 1..16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dav_z_,
    input  logic [7:0]  z,
    output logic        rfd_z,
    output logic        dav_,
    input  logic        rfd,
    output logic [11:0] s,
    output logic [7:0]  m
);

    typedef enum logic [1:0] {
        W_DAV   = 2'd0,
        W_END   = 2'd1,
        OUT     = 2'd2,
        OUT_END = 2'd3
    } state_t;

    // Count value at which the current window is complete.
    localparam logic [4:0] CNT_LAST = 5'(N);

    state_t      state_q;
    logic [11:0] acc_q;
    logic [7:0]  mx_q;
    logic [4:0]  cnt_q;
    logic        rfd_z_q;
    logic        dav_q;
    logic [11:0] s_q;
    logic [7:0]  m_q;

    logic [11:0] acc_d;
    logic [7:0]  mx_d;
    logic [4:0]  cnt_d;

    // Running sum/max/count as they would be after folding in the current z.
    always_comb begin
        acc_d = acc_q + {4'b0000, z};
        mx_d  = (z > mx_q) ? z : mx_q;
        cnt_d = cnt_q + 5'd1;
    end

    // Window FSM; every output is a register updated on the state transitions.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= W_DAV;
            acc_q   <= '0;
            mx_q    <= '0;
            cnt_q   <= '0;
            rfd_z_q <= 1'b1;
            dav_q   <= 1'b1;
            s_q     <= '0;
            m_q     <= '0;
        end else begin
            case (state_q)
                W_DAV: begin
                    if (!dav_z_) begin
                        acc_q   <= acc_d;
                        mx_q    <= mx_d;
                        cnt_q   <= cnt_d;
                        rfd_z_q <= 1'b0;
                        state_q <= W_END;
                    end
                end
                W_END: begin
                    // Upstream must release dav_z_ before the next sample;
                    // a completed window keeps rfd_z low until downstream acks.
                    if (dav_z_) begin
                        if (cnt_q == CNT_LAST) begin
                            s_q     <= acc_q;
                            m_q     <= mx_q;
                            dav_q   <= 1'b0;
                            state_q <= OUT;
                        end else begin
                            rfd_z_q <= 1'b1;
                            state_q <= W_DAV;
                        end
                    end
                end
                OUT: begin
                    // dav_ is low for at least this one cycle even if rfd is
                    // already low on entry.
                    if (!rfd) begin
                        dav_q   <= 1'b1;
                        state_q <= OUT_END;
                    end
                end
                OUT_END: begin
                    if (rfd) begin
                        acc_q   <= '0;
                        mx_q    <= '0;
                        cnt_q   <= '0;
                        rfd_z_q <= 1'b1;
                        state_q <= W_DAV;
                    end
                end
                default: begin
                    state_q <= W_DAV;
                end
            endcase
        end
    end

    assign rfd_z = rfd_z_q;
    assign dav_  = dav_q;
    assign s     = s_q;
    assign m     = m_q;

endmodule
`default_nettype wire

// File: tb/tb_z_window_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z_window_accumulator
//  Description : Scoreboard bench for z_window_accumulator. Three instances
//                (N = 4, 16, 1) share clock and reset; expected window
//                results are queued at stimulus time and popped by a monitor
//                on every falling edge of dav_.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z_window_accumulator;

    typedef struct {
        int inst;
        int s;
        int m;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [2:0]  dav_z_n;
    logic [7:0]  z [3];
    logic [2:0]  rfd_z;
    logic [2:0]  dav_n;
    logic [2:0]  rfd;
    logic [11:0] s [3];
    logic [7:0]  m [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   hold [3];
    exp_t sb [$];

    z_window_accumulator #(.N(4)) u_n4 (
        .clock(clock), .reset(reset), .dav_z_(dav_z_n[0]), .z(z[0]),
        .rfd_z(rfd_z[0]), .dav_(dav_n[0]), .rfd(rfd[0]), .s(s[0]), .m(m[0])
    );
    z_window_accumulator #(.N(16)) u_n16 (
        .clock(clock), .reset(reset), .dav_z_(dav_z_n[1]), .z(z[1]),
        .rfd_z(rfd_z[1]), .dav_(dav_n[1]), .rfd(rfd[1]), .s(s[1]), .m(m[1])
    );
    z_window_accumulator #(.N(1)) u_n1 (
        .clock(clock), .reset(reset), .dav_z_(dav_z_n[2]), .z(z[2]),
        .rfd_z(rfd_z[2]), .dav_(dav_n[2]), .rfd(rfd[2]), .s(s[2]), .m(m[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int es, input int em);
        exp_t e;
        e.inst = i;
        e.s    = es;
        e.m    = em;
        sb.push_back(e);
    endtask

    // Bounded wait at negedges for rfd_z of instance i to reach lvl.
    task automatic wait_rfd_z(input int i, input logic lvl);
        int k;
        k = 0;
        while (rfd_z[i] !== lvl && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (rfd_z[i] !== lvl) begin
            n_tests++;
            n_fail++;
            $display("FAIL rfd_z_timeout inst %0d: got %0b, required %0b", i, rfd_z[i], lvl);
        end
    endtask

    // One upstream sample transfer.
    task automatic send(input int i, input logic [7:0] v);
        wait_rfd_z(i, 1'b1);
        z[i]       = v;
        dav_z_n[i] = 1'b0;
        @(negedge clock);
        wait_rfd_z(i, 1'b0);
        dav_z_n[i] = 1'b1;
        @(negedge clock);
    endtask

    task automatic send4(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send(i, a);
        send(i, b);
        send(i, c);
        send(i, d);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Downstream consumer: acknowledges dav_ after hold[i] cycles.
    task automatic consumer(input int i);
        int k;
        forever begin
            @(negedge clock);
            if (dav_n[i] === 1'b0) begin
                repeat (hold[i]) @(negedge clock);
                rfd[i] = 1'b0;
                k = 0;
                while (dav_n[i] !== 1'b1 && k < 1000) begin
                    @(negedge clock);
                    k++;
                end
                rfd[i] = 1'b1;
            end
        end
    endtask

    // Monitor: pop and compare on each dav_ fall, verify s/m hold while low.
    initial begin
        logic [2:0] prev_dav;
        int         held_s [3];
        int         held_m [3];
        exp_t       e;
        prev_dav = 3'b111;
        for (int j = 0; j < 3; j++) begin
            held_s[j] = 0;
            held_m[j] = 0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                if (dav_n[i] === 1'b0 && prev_dav[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output inst %0d: got s=%0d m=%0d, required no output",
                                 i, s[i], m[i]);
                    end else begin
                        e = sb.pop_front();
                        check("out_inst", i, e.inst);
                        check("out_s", int'(s[i]), e.s);
                        check("out_m", int'(m[i]), e.m);
                    end
                    held_s[i] = int'(s[i]);
                    held_m[i] = int'(m[i]);
                end else if (dav_n[i] === 1'b0) begin
                    check("hold_s", int'(s[i]), held_s[i]);
                    check("hold_m", int'(m[i]), held_m[i]);
                end
                prev_dav[i] = dav_n[i];
            end
        end
    end

    initial begin
        fork
            consumer(0);
            consumer(1);
            consumer(2);
        join_none
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset   = 1'b1;
        dav_z_n = 3'b111;
        rfd     = 3'b111;
        for (int i = 0; i < 3; i++) begin
            z[i]    = 8'd0;
            hold[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check("rst_rfd_z", int'(rfd_z[i]), 1);
            check("rst_dav_", int'(dav_n[i]), 1);
            check("rst_s", int'(s[i]), 0);
            check("rst_m", int'(m[i]), 0);
        end
        reset = 1'b0;
        @(negedge clock);

        // N=4 basic windows
        push(0, 19, 8);
        send4(0, 8'd8, 8'd0, 8'd4, 8'd7);
        push(0, 17, 6);
        send4(0, 8'd6, 8'd2, 8'd4, 8'd5);
        wait_drain();

        // Back-pressure with an early next sample
        hold[0] = 20;
        push(0, 14, 8);
        push(0, 17, 8);
        send4(0, 8'd0, 8'd8, 8'd4, 8'd2);
        z[0]       = 8'd5;
        dav_z_n[0] = 1'b0;
        cnt = 0;
        while (rfd_z[0] === 1'b0 && cnt < 300) begin
            @(negedge clock);
            cnt++;
        end
        check("bp_stall_ge_20", int'(cnt >= 20), 1);
        check("bp_released", int'(rfd_z[0]), 1);
        wait_rfd_z(0, 1'b0);
        dav_z_n[0] = 1'b1;
        @(negedge clock);
        hold[0] = 0;
        send(0, 8'd0);
        send(0, 8'd4);
        send(0, 8'd8);
        wait_drain();

        // N=16 all 8s, then all 0s
        push(1, 128, 8);
        for (int k = 0; k < 16; k++) send(1, 8'd8);
        push(1, 0, 0);
        for (int k = 0; k < 16; k++) send(1, 8'd0);
        wait_drain();

        // N=1 every sample is a window
        push(2, 0, 0);
        send(2, 8'd0);
        push(2, 200, 200);
        send(2, 8'd200);
        push(2, 37, 37);
        send(2, 8'd37);
        wait_drain();

        // Reset mid-window discards the partial window
        send(0, 8'd8);
        send(0, 8'd8);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_rfd_z", int'(rfd_z[0]), 1);
        push(0, 10, 4);
        send4(0, 8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();

        // Reset while dav_ is low
        hold[0] = 10;
        push(0, 4, 1);
        send4(0, 8'd1, 8'd1, 8'd1, 8'd1);
        cnt = 0;
        while (dav_n[0] !== 1'b0 && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check("rst_out_dav_low_seen", int'(dav_n[0]), 0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_out_dav_", int'(dav_n[0]), 1);
        check("rst_out_s", int'(s[0]), 0);
        check("rst_out_m", int'(m[0]), 0);
        reset = 1'b0;
        hold[0] = 0;
        repeat (20) @(negedge clock);
        push(0, 4, 1);
        send4(0, 8'd1, 8'd1, 8'd1, 8'd1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
